tag_cmp_rr: RTL and testbench
=============================

Name: tag_cmp_rr

Overview:
- Arbitrates NR_PORTS requesters onto one shared set-associative tag/data SRAM port.
- Performs the per-way tag compare aligned to a configurable SRAM read latency.
- Successor to the single-cycle fixed-priority tag comparator:
  - round-robin fairness with per-port lock;
  - parametrised way count and read latency;
  - a pipelined per-port response with hit, multi-hit and way-index outputs.
- Sits between the cache controller's miss/store/load units and the way SRAM banks.

Parameters:
- NR_PORTS, 3, number of requesting ports (1..8).
- NR_WAYS, 8, cache associativity (1..16).
- ADDR_WIDTH, 64, SRAM index/offset address width.
- TAG_WIDTH, 44, tag width compared per way.
- DATA_WIDTH, 128, data bits per way entry.
- BE_WIDTH, 20, byte/field-enable width per request, passed through unchanged.
- READ_LATENCY, 1, SRAM cycles from req_o to rdata_i valid (1..4).
- Derived: EW = TAG_WIDTH+DATA_WIDTH+2. Each way entry is {tag, data, dirty, valid}, with valid at bit 0 and dirty at bit 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NR_PORTS*NR_WAYS  per-port way-enable request; a port is requesting when its slice is nonzero.
- lock_i  in  NR_PORTS  hold the grant on this port next cycle.
- gnt_o  out  NR_PORTS  one-hot grant, combinational.
- addr_i  in  NR_PORTS*ADDR_WIDTH  per-port SRAM address.
- wdata_i  in  NR_PORTS*EW  per-port write entry.
- we_i  in  NR_PORTS  per-port write enable.
- be_i  in  NR_PORTS*BE_WIDTH  per-port enables.
- tag_i  in  NR_PORTS*TAG_WIDTH  compare tag, sampled in the grant cycle.
- req_o  out  NR_WAYS  SRAM way enables.
- addr_o  out  ADDR_WIDTH  SRAM address.
- wdata_o  out  EW  SRAM write entry.
- we_o  out  1  SRAM write enable.
- be_o  out  BE_WIDTH  SRAM enables.
- rdata_i  in  NR_WAYS*EW  SRAM read data, valid READ_LATENCY cycles after req_o.
- rvalid_o  out  NR_PORTS  one-hot: response for that port is on the outputs this cycle.
- rdata_o  out  NR_WAYS*EW  rdata_i passed through.
- hit_way_o  out  NR_WAYS  per-way hit: entry valid and tag equal.
- hit_o  out  1  OR of hit_way_o, qualified by any rvalid_o.
- hit_idx_o  out  clog2(NR_WAYS) (min 1)  index of the lowest set bit of hit_way_o.
- multi_hit_o  out  1  more than one hit_way_o bit set while rvalid; error flag.

Behaviour:
- Arbitration (combinational):
  - Search starts at port rr_q+1 modulo NR_PORTS and grants the first requesting port.
  - If lock_q is set and port lock_id_q is still requesting, that port wins unconditionally.
  - If the locked port has dropped its request, the lock is released and normal round-robin search applies.
  - If no port requests, gnt_o=0 and all SRAM outputs are 0.
- SRAM drive: the granted port's addr, wdata, we, be and way-enable drive the SRAM outputs in the same cycle.
- State updates on each grant:
  - rr_q advances to the granted index only when the grant is not lock-held.
  - lock_q <= lock_i[granted] and lock_id_q <= granted index.
  - With no grant, lock_q clears and rr_q is unchanged.
- Response pipeline:
  - READ_LATENCY stages, each holding {valid, one-hot port id, tag}.
  - A stage is valid only for a granted read (we=0); writes never produce rvalid.
  - Stage 0 captures on the grant cycle; the last stage drives rvalid_o and the compare tag.
  - Exactly one response per granted read, emitted READ_LATENCY cycles after its grant.
  - Back-to-back grants pipeline fully, giving one response per cycle.
- Compare:
  - hit_way_o[w] = rvalid & rdata_i[w].valid & (rdata_i[w].tag == pipe_tag).
  - hit_way_o=0, hit_o=0, multi_hit_o=0 when no stage is valid.
  - With zero hits, hit_idx_o=0.
- Reset values:
  - rr_q = NR_PORTS-1, so port 0 has first priority.
  - lock_q=0, lock_id_q=0, all pipeline valids 0.
  - All registered outputs are 0 and rvalid_o=0.
- Reset mid-operation: in-flight responses are discarded, with no rvalid after reset deassertion for pre-reset grants.
- Single-port degenerate case (NR_PORTS=1): a request is always granted and rr_q is constant.
- Simultaneous events: lock_i asserted together with we_i on the same grant is legal; the lock still holds.

Test Plan:
- Reset then all three ports request continuously, reads, READ_LATENCY=1 → grants cycle 0,1,2,0,… and rvalid_o=001,010,100,… one cycle after each grant.
- Port 1 alone, addr=0x40, tag_i=0xABC; way 5 returns {tag=0xABC, valid=1} and the others mismatch → after READ_LATENCY cycles rvalid_o=010, hit_way_o=0x20, hit_o=1, hit_idx_o=5, multi_hit_o=0.
- Port 0 with lock_i=1 for 4 cycles while ports 1 and 2 request → gnt_o=001 for 5 consecutive cycles; after the lock drops, the next grant is port 1.
- Ways 2 and 6 both valid with matching tag → hit_way_o=0x44, hit_idx_o=2, multi_hit_o=1.
- Write grant (we_i=1) from port 2 interleaved with reads, READ_LATENCY=3 → we_o=1 in the grant cycle; no rvalid for port 2; read responses still appear exactly 3 cycles after their grants.
- Assert rst_ni low with 2 reads in flight (READ_LATENCY=3) → rvalid_o stays 0 after release; the next request to port 0 wins first.

Source files
------------

// File: rtl/tag_cmp_rr.sv
// Round-robin arbiter (with per-port lock) in front of a shared set-associative tag/data SRAM port,
// with a READ_LATENCY-deep response pipeline that aligns the per-way tag compare to the returning read data.
module tag_cmp_rr #(
    parameter int NR_PORTS     = 3,
    parameter int NR_WAYS      = 8,
    parameter int ADDR_WIDTH   = 64,
    parameter int TAG_WIDTH    = 44,
    parameter int DATA_WIDTH   = 128,
    parameter int BE_WIDTH     = 20,
    parameter int READ_LATENCY = 1,
    localparam int EW = TAG_WIDTH + DATA_WIDTH + 2,
    localparam int IW = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NR_PORTS*NR_WAYS-1:0]    req_i,
    input  logic [NR_PORTS-1:0]            lock_i,
    output logic [NR_PORTS-1:0]            gnt_o,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NR_PORTS*EW-1:0]         wdata_i,
    input  logic [NR_PORTS-1:0]            we_i,
    input  logic [NR_PORTS*BE_WIDTH-1:0]   be_i,
    input  logic [NR_PORTS*TAG_WIDTH-1:0]  tag_i,
    output logic [NR_WAYS-1:0]             req_o,
    output logic [ADDR_WIDTH-1:0]          addr_o,
    output logic [EW-1:0]                  wdata_o,
    output logic                           we_o,
    output logic [BE_WIDTH-1:0]            be_o,
    input  logic [NR_WAYS*EW-1:0]          rdata_i,
    output logic [NR_PORTS-1:0]            rvalid_o,
    output logic [NR_WAYS*EW-1:0]          rdata_o,
    output logic [NR_WAYS-1:0]             hit_way_o,
    output logic                           hit_o,
    output logic [IW-1:0]                  hit_idx_o,
    output logic                           multi_hit_o
);

    localparam int PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int RL = READ_LATENCY;

    logic [NR_PORTS-1:0]  port_req;
    logic [PW-1:0]        rr_q, rr_d, lock_id_q, lock_id_d, gnt_idx;
    logic                 lock_q, lock_d, lock_hold, gnt_vld;
    logic                 we_sel;
    logic [TAG_WIDTH-1:0] tag_sel;
    int                   cand;

    logic [RL-1:0]        pipe_vld_q, pipe_vld_d;
    logic [NR_PORTS-1:0]  pipe_id_q  [RL];
    logic [NR_PORTS-1:0]  pipe_id_d  [RL];
    logic [TAG_WIDTH-1:0] pipe_tag_q [RL];
    logic [TAG_WIDTH-1:0] pipe_tag_d [RL];

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            port_req[p] = |req_i[p*NR_WAYS +: NR_WAYS];
        end
    end

    // A held lock beats the round-robin search; a dropped request releases it.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        lock_hold = lock_q && port_req[lock_id_q];
        if (lock_hold) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_id_q;
        end else begin
            for (int i = 1; i <= NR_PORTS; i++) begin
                cand = (int'(rr_q) + i) % NR_PORTS;
                if (!gnt_vld && port_req[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'(cand);
                end
            end
        end
    end

    always_comb begin
        gnt_o   = '0;
        req_o   = '0;
        addr_o  = '0;
        wdata_o = '0;
        we_o    = 1'b0;
        be_o    = '0;
        we_sel  = 1'b0;
        tag_sel = '0;
        if (gnt_vld) begin
            gnt_o[gnt_idx] = 1'b1;
            req_o          = req_i[int'(gnt_idx)*NR_WAYS +: NR_WAYS];
            addr_o         = addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_o        = wdata_i[int'(gnt_idx)*EW +: EW];
            we_o           = we_i[gnt_idx];
            be_o           = be_i[int'(gnt_idx)*BE_WIDTH +: BE_WIDTH];
            we_sel         = we_i[gnt_idx];
            tag_sel        = tag_i[int'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH];
        end
    end

    always_comb begin
        rr_d      = (gnt_vld && !lock_hold) ? gnt_idx : rr_q;
        lock_d    = gnt_vld ? lock_i[gnt_idx] : 1'b0;
        lock_id_d = gnt_vld ? gnt_idx : lock_id_q;
    end

    // Only reads enter the response pipeline; writes are fire-and-forget.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = gnt_vld && !we_sel;
        pipe_id_d[0]  = (gnt_vld && !we_sel) ? gnt_o : '0;
        pipe_tag_d[0] = tag_sel;
        for (int s = 1; s < RL; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_id_d[s]  = pipe_id_q[s-1];
            pipe_tag_d[s] = pipe_tag_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= PW'(NR_PORTS - 1);
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            pipe_vld_q <= '0;
            for (int s = 0; s < RL; s++) begin
                pipe_id_q[s]  <= '0;
                pipe_tag_q[s] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            pipe_vld_q <= pipe_vld_d;
            for (int s = 0; s < RL; s++) begin
                pipe_id_q[s]  <= pipe_id_d[s];
                pipe_tag_q[s] <= pipe_tag_d[s];
            end
        end
    end

    assign rvalid_o = pipe_vld_q[RL-1] ? pipe_id_q[RL-1] : '0;
    assign rdata_o  = rdata_i;

    // Entry layout per way: {tag, data, dirty, valid}.
    always_comb begin
        hit_way_o = '0;
        for (int w = 0; w < NR_WAYS; w++) begin
            hit_way_o[w] = pipe_vld_q[RL-1] && rdata_i[w*EW] &&
                           (rdata_i[w*EW+EW-1 -: TAG_WIDTH] == pipe_tag_q[RL-1]);
        end
    end

    always_comb begin
        hit_idx_o = '0;
        for (int w = NR_WAYS - 1; w >= 0; w--) begin
            if (hit_way_o[w]) hit_idx_o = IW'(w);
        end
    end

    assign hit_o       = |hit_way_o;
    assign multi_hit_o = |(hit_way_o & (hit_way_o - NR_WAYS'(1)));

endmodule

// File: tb/tb_tag_cmp_rr.sv
// Bench for tag_cmp_rr: two instances (read latency 1 and 3) share all inputs and are
// checked against a queue-based reference of grants and due responses.
module tb_tag_cmp_rr;

    localparam int NP = 3;
    localparam int NW = 8;
    localparam int AW = 64;
    localparam int TW = 44;
    localparam int DW = 128;
    localparam int BW = 20;
    localparam int EW = TW + DW + 2;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [NP*NW-1:0] req;
    logic [NP-1:0]    lock, we;
    logic [NP*AW-1:0] addr;
    logic [NP*EW-1:0] wdata;
    logic [NP*BW-1:0] be;
    logic [NP*TW-1:0] tag;
    logic [NW*EW-1:0] rdata;

    logic [NP-1:0] gnt_1, gnt_3, rv_1, rv_3;
    logic [NW-1:0] reqo_1, reqo_3, hw_1, hw_3;
    logic [AW-1:0] addro_1, addro_3;
    logic [EW-1:0] wdo_1, wdo_3;
    logic          weo_1, weo_3, hit_1, hit_3, mh_1, mh_3;
    logic [BW-1:0] beo_1, beo_3;
    logic [NW*EW-1:0] rdo_1, rdo_3;
    logic [IW-1:0] idx_1, idx_3;

    always #5 clk = ~clk;

    tag_cmp_rr #(.NR_PORTS(NP), .NR_WAYS(NW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DATA_WIDTH(DW),
                 .BE_WIDTH(BW), .READ_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .lock_i(lock), .gnt_o(gnt_1), .addr_i(addr),
        .wdata_i(wdata), .we_i(we), .be_i(be), .tag_i(tag), .req_o(reqo_1), .addr_o(addro_1),
        .wdata_o(wdo_1), .we_o(weo_1), .be_o(beo_1), .rdata_i(rdata), .rvalid_o(rv_1),
        .rdata_o(rdo_1), .hit_way_o(hw_1), .hit_o(hit_1), .hit_idx_o(idx_1), .multi_hit_o(mh_1));

    tag_cmp_rr #(.NR_PORTS(NP), .NR_WAYS(NW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DATA_WIDTH(DW),
                 .BE_WIDTH(BW), .READ_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .lock_i(lock), .gnt_o(gnt_3), .addr_i(addr),
        .wdata_i(wdata), .we_i(we), .be_i(be), .tag_i(tag), .req_o(reqo_3), .addr_o(addro_3),
        .wdata_o(wdo_3), .we_o(weo_3), .be_o(beo_3), .rdata_i(rdata), .rvalid_o(rv_3),
        .rdata_o(rdo_3), .hit_way_o(hw_3), .hit_o(hit_3), .hit_idx_o(idx_3), .multi_hit_o(mh_3));

    typedef struct {
        int          due;
        int          port;
        logic [TW-1:0] tag;
    } resp_t;

    resp_t q1[$];
    resp_t q3[$];
    int    m_rr, m_lock_id, cyc, n_checks, n_fail;
    bit    m_lock;
    bit    e_v1, e_v3;
    logic [NP-1:0] e_rv1, e_rv3;
    logic [TW-1:0] e_tag1, e_tag3;

    function automatic logic [EW-1:0] mk_entry(input logic [TW-1:0] t, input logic v);
        logic [DW-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        return {t, d, 1'($urandom), v};
    endfunction

    function automatic logic [NW-1:0] ref_hits(input bit v, input logic [TW-1:0] t);
        logic [NW-1:0] h;
        logic [EW-1:0] e;
        h = '0;
        if (v) begin
            for (int w = 0; w < NW; w++) begin
                e = rdata[w*EW +: EW];
                h[w] = e[0] && (e[EW-1 -: TW] == t);
            end
        end
        return h;
    endfunction

    function automatic logic [IW-1:0] low_idx(input logic [NW-1:0] h);
        for (int w = 0; w < NW; w++) begin
            if (h[w]) return IW'(w);
        end
        return '0;
    endfunction

    function automatic bit port_requesting(input int p);
        return |req[p*NW +: NW];
    endfunction

    function automatic int model_grant();
        int p;
        if (m_lock && port_requesting(m_lock_id)) return m_lock_id;
        for (int i = 1; i <= NP; i++) begin
            p = (m_rr + i) % NP;
            if (port_requesting(p)) return p;
        end
        return -1;
    endfunction

    task automatic model_resp();
        e_v1 = 0; e_rv1 = '0; e_tag1 = '0;
        e_v3 = 0; e_rv3 = '0; e_tag3 = '0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e_v1 = 1; e_rv1 = NP'(1) << q1[0].port; e_tag1 = q1[0].tag;
        end
        if (q3.size() > 0 && q3[0].due == cyc) begin
            e_v3 = 1; e_rv3 = NP'(1) << q3[0].port; e_tag3 = q3[0].tag;
        end
    endtask

    // Advance the reference by one clock, then move to just after the edge.
    task automatic tick();
        resp_t r;
        int    g;
        bit    held;
        g    = model_grant();
        held = m_lock && port_requesting(m_lock_id);
        if (g >= 0) begin
            if (!held) m_rr = g;
            m_lock    = lock[g];
            m_lock_id = g;
            if (!we[g]) begin
                r.port = g;
                r.tag  = tag[g*TW +: TW];
                r.due  = cyc + 1; q1.push_back(r);
                r.due  = cyc + 3; q3.push_back(r);
            end
        end else begin
            m_lock = 0;
        end
        while (q1.size() > 0 && q1[0].due <= cyc) void'(q1.pop_front());
        while (q3.size() > 0 && q3[0].due <= cyc) void'(q3.pop_front());
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0; be = '0; tag = '0;
    endtask

    task automatic set_req(input logic [NP-1:0] ports, input logic [NW-1:0] wm);
        for (int p = 0; p < NP; p++) req[p*NW +: NW] = ports[p] ? wm : '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_rr = NP - 1; m_lock = 0; m_lock_id = 0;
        q1.delete(); q3.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        clear_inputs();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (gnt_1 !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=000", gnt_1); end
        n_checks++; if (rv_1 !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid1 got=%b exp=000", rv_1); end
        n_checks++; if (rv_3 !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid3 got=%b exp=000", rv_3); end
        n_checks++; if (reqo_1 !== 8'h00 || weo_1 !== 1'b0 || addro_1 !== '0) begin
            n_fail++; $display("FAIL reset_sram got req=%h we=%b addr=%h exp=0", reqo_1, weo_1, addro_1);
        end
        n_checks++; if (hit_1 !== 1'b0 || mh_1 !== 1'b0 || hw_1 !== 8'h00) begin
            n_fail++; $display("FAIL reset_hit got hit=%b mh=%b hw=%h exp=0", hit_1, mh_1, hw_1);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] eg, erv;
        clear_inputs();
        set_req(3'b111, 8'h01);
        for (int k = 0; k < 9; k++) begin
            #1;
            eg = 3'b001 << (k % 3);
            n_checks++; if (gnt_1 !== eg) begin n_fail++; $display("FAIL rr_gnt1 k=%0d got=%b exp=%b", k, gnt_1, eg); end
            n_checks++; if (gnt_3 !== eg) begin n_fail++; $display("FAIL rr_gnt3 k=%0d got=%b exp=%b", k, gnt_3, eg); end
            erv = (k >= 1) ? (3'b001 << ((k - 1) % 3)) : 3'b000;
            n_checks++; if (rv_1 !== erv) begin n_fail++; $display("FAIL rr_rvalid1 k=%0d got=%b exp=%b", k, rv_1, erv); end
            erv = (k >= 3) ? (3'b001 << ((k - 3) % 3)) : 3'b000;
            n_checks++; if (rv_3 !== erv) begin n_fail++; $display("FAIL rr_rvalid3 k=%0d got=%b exp=%b", k, rv_3, erv); end
            tick();
        end
    endtask

    task automatic test_hit();
        clear_inputs();
        for (int w = 0; w < NW; w++) rdata[w*EW +: EW] = mk_entry((w == 5) ? TW'(12'hABC) : TW'(12'hABD), 1'b1);
        set_req(3'b010, 8'hFF);
        addr[1*AW +: AW] = 64'h40;
        tag[1*TW +: TW]  = TW'(12'hABC);
        #1;
        n_checks++; if (gnt_1 !== 3'b010) begin n_fail++; $display("FAIL hit_gnt got=%b exp=010", gnt_1); end
        n_checks++; if (addro_1 !== 64'h40 || reqo_1 !== 8'hFF) begin
            n_fail++; $display("FAIL hit_sram got addr=%h req=%h exp addr=40 req=ff", addro_1, reqo_1);
        end
        tick();
        clear_inputs();
        for (int k = 1; k <= 3; k++) begin
            #1;
            if (k == 1) begin
                n_checks++; if (rv_1 !== 3'b010 || hw_1 !== 8'h20 || hit_1 !== 1'b1 || idx_1 !== 3'd5 || mh_1 !== 1'b0) begin
                    n_fail++; $display("FAIL hit_l1 got rv=%b hw=%h hit=%b idx=%0d mh=%b exp rv=010 hw=20 hit=1 idx=5 mh=0",
                                       rv_1, hw_1, hit_1, idx_1, mh_1);
                end
                n_checks++; if (rv_3 !== 3'b000 || hw_3 !== 8'h00 || hit_3 !== 1'b0) begin
                    n_fail++; $display("FAIL hit_l3_early got rv=%b hw=%h hit=%b exp 0", rv_3, hw_3, hit_3);
                end
            end
            if (k == 3) begin
                n_checks++; if (rv_3 !== 3'b010 || hw_3 !== 8'h20 || hit_3 !== 1'b1 || idx_3 !== 3'd5 || mh_3 !== 1'b0) begin
                    n_fail++; $display("FAIL hit_l3 got rv=%b hw=%h hit=%b idx=%0d mh=%b exp rv=010 hw=20 hit=1 idx=5 mh=0",
                                       rv_3, hw_3, hit_3, idx_3, mh_3);
                end
            end
            tick();
        end
    endtask

    task automatic test_lock();
        logic [NP-1:0] exp_g [7];
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100};
        do_reset();
        set_req(3'b111, 8'h0F);
        for (int k = 0; k < 7; k++) begin
            lock = (k < 4) ? 3'b001 : 3'b000;
            #1;
            n_checks++; if (gnt_1 !== exp_g[k]) begin n_fail++; $display("FAIL lock_gnt k=%0d got=%b exp=%b", k, gnt_1, exp_g[k]); end
            tick();
        end
    endtask

    task automatic test_multi_hit();
        logic [TW-1:0] t;
        t = TW'({$urandom, $urandom});
        clear_inputs();
        for (int w = 0; w < NW; w++) begin
            if (w == 2 || w == 6) rdata[w*EW +: EW] = mk_entry(t, 1'b1);
            else if (w == 3)      rdata[w*EW +: EW] = mk_entry(t, 1'b0);
            else                  rdata[w*EW +: EW] = mk_entry(t ^ TW'(1), 1'b1);
        end
        set_req(3'b001, 8'h01);
        tag[TW-1:0] = t;
        tick();
        clear_inputs();
        for (int k = 1; k <= 3; k++) begin
            #1;
            if (k == 1) begin
                n_checks++; if (hw_1 !== 8'h44 || idx_1 !== 3'd2 || mh_1 !== 1'b1 || hit_1 !== 1'b1) begin
                    n_fail++; $display("FAIL multi_l1 got hw=%h idx=%0d mh=%b hit=%b exp hw=44 idx=2 mh=1 hit=1", hw_1, idx_1, mh_1, hit_1);
                end
            end
            if (k == 3) begin
                n_checks++; if (hw_3 !== 8'h44 || idx_3 !== 3'd2 || mh_3 !== 1'b1 || rv_3 !== 3'b001) begin
                    n_fail++; $display("FAIL multi_l3 got hw=%h idx=%0d mh=%b rv=%b exp hw=44 idx=2 mh=1 rv=001", hw_3, idx_3, mh_3, rv_3);
                end
            end
            tick();
        end
    endtask

    task automatic test_write_interleave();
        logic [NP-1:0] t_req [9], t_we [9], t_lk [9], t_g [9], t_rv1 [9], t_rv3 [9];
        logic          t_weo [9];
        t_req = '{3'b001, 3'b100, 3'b110, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        t_we  = '{3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        t_lk  = '{3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        t_g   = '{3'b001, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        t_weo = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t_rv1 = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
        t_rv3 = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000};
        clear_inputs();
        for (int k = 0; k < 9; k++) begin
            set_req(t_req[k], 8'h03);
            we = t_we[k]; lock = t_lk[k];
            #1;
            n_checks++; if (gnt_3 !== t_g[k]) begin n_fail++; $display("FAIL wr_gnt k=%0d got=%b exp=%b", k, gnt_3, t_g[k]); end
            n_checks++; if (weo_3 !== t_weo[k]) begin n_fail++; $display("FAIL wr_we k=%0d got=%b exp=%b", k, weo_3, t_weo[k]); end
            n_checks++; if (rv_1 !== t_rv1[k]) begin n_fail++; $display("FAIL wr_rvalid1 k=%0d got=%b exp=%b", k, rv_1, t_rv1[k]); end
            n_checks++; if (rv_3 !== t_rv3[k]) begin n_fail++; $display("FAIL wr_rvalid3 k=%0d got=%b exp=%b", k, rv_3, t_rv3[k]); end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        clear_inputs();
        set_req(3'b010, 8'h01); tick();
        set_req(3'b100, 8'h01); tick();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        n_checks++; if (rv_3 !== 3'b000) begin n_fail++; $display("FAIL rstmid_async got=%b exp=000", rv_3); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_rr = NP - 1; m_lock = 0; m_lock_id = 0;
        q1.delete(); q3.delete();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (rv_3 !== 3'b000 || hit_3 !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_rvalid k=%0d got rv=%b hit=%b exp 0", k, rv_3, hit_3);
            end
            tick();
        end
        set_req(3'b111, 8'h01);
        #1;
        n_checks++; if (gnt_1 !== 3'b001 || gnt_3 !== 3'b001) begin
            n_fail++; $display("FAIL rstmid_gnt got=%b/%b exp=001", gnt_1, gnt_3);
        end
        tick();
    endtask

    task automatic test_random();
        int g;
        logic [NP-1:0] eg;
        logic [NW-1:0] ereq, eh1, eh3;
        logic [AW-1:0] eaddr;
        logic [EW-1:0] ewd;
        logic [BW-1:0] ebe;
        logic          ewe;
        for (int k = 0; k < 300; k++) begin
            for (int p = 0; p < NP; p++) begin
                req[p*NW +: NW]   = ($urandom_range(0, 3) == 0) ? '0 : NW'($urandom);
                lock[p]           = ($urandom_range(0, 2) == 0);
                we[p]             = ($urandom_range(0, 3) == 0);
                addr[p*AW +: AW]  = {$urandom, $urandom};
                be[p*BW +: BW]    = BW'($urandom);
                wdata[p*EW +: EW] = mk_entry(TW'({$urandom, $urandom}), 1'($urandom));
                tag[p*TW +: TW]   = TW'($urandom_range(0, 3));
            end
            for (int w = 0; w < NW; w++) rdata[w*EW +: EW] = mk_entry(TW'($urandom_range(0, 3)), 1'($urandom));
            #1;
            g = model_grant();
            model_resp();
            eg = '0; ereq = '0; eaddr = '0; ewd = '0; ebe = '0; ewe = 1'b0;
            if (g >= 0) begin
                eg    = NP'(1) << g;
                ereq  = req[g*NW +: NW];
                eaddr = addr[g*AW +: AW];
                ewd   = wdata[g*EW +: EW];
                ebe   = be[g*BW +: BW];
                ewe   = we[g];
            end
            eh1 = ref_hits(e_v1, e_tag1);
            eh3 = ref_hits(e_v3, e_tag3);
            n_checks++; if (gnt_1 !== eg || gnt_3 !== eg) begin
                n_fail++; $display("FAIL rnd_gnt k=%0d got=%b/%b exp=%b", k, gnt_1, gnt_3, eg);
            end
            n_checks++; if (reqo_1 !== ereq || addro_1 !== eaddr || weo_1 !== ewe || beo_1 !== ebe) begin
                n_fail++; $display("FAIL rnd_sram k=%0d got req=%h addr=%h we=%b be=%h exp req=%h addr=%h we=%b be=%h",
                                   k, reqo_1, addro_1, weo_1, beo_1, ereq, eaddr, ewe, ebe);
            end
            n_checks++; if (wdo_1 !== ewd) begin n_fail++; $display("FAIL rnd_wdata k=%0d got=%h exp=%h", k, wdo_1, ewd); end
            n_checks++; if (rdo_3 !== rdata) begin n_fail++; $display("FAIL rnd_rdata k=%0d passthrough differs", k); end
            n_checks++; if (rv_1 !== e_rv1) begin n_fail++; $display("FAIL rnd_rvalid1 k=%0d got=%b exp=%b", k, rv_1, e_rv1); end
            n_checks++; if (rv_3 !== e_rv3) begin n_fail++; $display("FAIL rnd_rvalid3 k=%0d got=%b exp=%b", k, rv_3, e_rv3); end
            n_checks++; if (hw_1 !== eh1 || hit_1 !== (|eh1) || idx_1 !== low_idx(eh1) || mh_1 !== ($countones(eh1) > 1)) begin
                n_fail++; $display("FAIL rnd_cmp1 k=%0d got hw=%h hit=%b idx=%0d mh=%b exp hw=%h", k, hw_1, hit_1, idx_1, mh_1, eh1);
            end
            n_checks++; if (hw_3 !== eh3 || hit_3 !== (|eh3) || idx_3 !== low_idx(eh3) || mh_3 !== ($countones(eh3) > 1)) begin
                n_fail++; $display("FAIL rnd_cmp3 k=%0d got hw=%h hit=%b idx=%0d mh=%b exp hw=%h", k, hw_3, hit_3, idx_3, mh_3, eh3);
            end
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0;
        rdata = '0;
        clear_inputs();
        test_reset();
        test_round_robin();
        drain();
        test_hit();
        drain();
        test_lock();
        drain();
        test_multi_hit();
        drain();
        test_write_interleave();
        drain();
        test_reset_midflight();
        drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
